analog_pin_scan_ctrl: RTL and testbench

Scan controller that sequences the six analog output strobes (A0..A5) of the pin-out interface. It latches a pin-enable mask and a per-pin dwell length on a start request, then drives exactly one enabled strobe at a time, in ascending index order, with a one-cycle break-before-make gap between pins. Scans run either once or continuously until stopped. It sits between the host-side command logic and the analog pin outputs, replacing free-running rotation with a masked, timed, handshaked scan.

---
 rtl/analog_pin_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_analog_pin_scan_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/analog_pin_scan_ctrl.sv
// Masked, timed scan over six analog strobes: one pin at a time, ascending order,
// a one-cycle all-zero gap between pins, single-shot or continuous.
module analog_pin_scan_ctrl #(
   parameter int NUM_PINS = 6,
   parameter int DWELL_W  = 8
) (
   input  logic                arduino_clk,
   input  logic                arduino_rst_n,
   input  logic                start,
   input  logic                stop,
   input  logic                continuous,
   input  logic [NUM_PINS-1:0] pin_mask,
   input  logic [DWELL_W-1:0]  dwell,
   output logic [NUM_PINS-1:0] pin_sel,
   output logic [2:0]          pin_idx,
   output logic                sample_strobe,
   output logic                busy,
   output logic                done,
   output logic [1:0]          state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t              state_q;
   logic [NUM_PINS-1:0] mask_q;
   logic [DWELL_W-1:0]  dwell_q;
   logic                cont_q;
   logic [2:0]          idx_q;
   logic [DWELL_W-1:0]  cnt_q;
   logic [NUM_PINS-1:0] pin_sel_q;
   logic                sample_q;
   logic                busy_q;
   logic                done_q;

   logic                first_found;
   logic [2:0]          first_idx;
   logic                next_found;
   logic [2:0]          next_idx;
   logic [2:0]          wrap_idx;
   logic [DWELL_W-1:0]  cnt_inc;

   function automatic logic [NUM_PINS-1:0] onehot(input logic [2:0] i);
      return {{(NUM_PINS-1){1'b0}}, 1'b1} << i;
   endfunction

   // Downward loops leave the lowest qualifying index as the final assignment.
   always_comb begin
      first_found = 1'b0;
      first_idx   = '0;
      next_found  = 1'b0;
      next_idx    = '0;
      wrap_idx    = '0;
      for (int i = NUM_PINS - 1; i >= 0; i--) begin
         if (pin_mask[i]) begin
            first_found = 1'b1;
            first_idx   = 3'(i);
         end
         if (mask_q[i] && (3'(i) > idx_q)) begin
            next_found = 1'b1;
            next_idx   = 3'(i);
         end
         if (mask_q[i]) begin
            wrap_idx = 3'(i);
         end
      end
   end

   assign cnt_inc = cnt_q + 1'b1;

   always_ff @(posedge arduino_clk or negedge arduino_rst_n) begin
      if (!arduino_rst_n) begin
         state_q   <= IDLE;
         mask_q    <= '0;
         dwell_q   <= '0;
         cont_q    <= 1'b0;
         idx_q     <= '0;
         cnt_q     <= '0;
         pin_sel_q <= '0;
         sample_q  <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         sample_q <= 1'b0;
         done_q   <= 1'b0;
         if (stop) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            pin_sel_q <= '0;
            busy_q    <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start) begin
                     mask_q  <= pin_mask;
                     dwell_q <= dwell;
                     cont_q  <= continuous;
                     if (first_found) begin
                        state_q   <= DRIVE;
                        idx_q     <= first_idx;
                        pin_sel_q <= onehot(first_idx);
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        sample_q  <= (dwell == '0);
                     end else begin
                        done_q <= 1'b1;
                     end
                  end
               end
               DRIVE: begin
                  if (cnt_q == dwell_q) begin
                     state_q   <= GAP;
                     pin_sel_q <= '0;
                  end else begin
                     cnt_q    <= cnt_inc;
                     sample_q <= (cnt_inc == dwell_q);
                  end
               end
               GAP: begin
                  if (next_found || cont_q) begin
                     state_q   <= DRIVE;
                     idx_q     <= next_found ? next_idx : wrap_idx;
                     pin_sel_q <= onehot(next_found ? next_idx : wrap_idx);
                     cnt_q     <= '0;
                     sample_q  <= (dwell_q == '0);
                  end else begin
                     state_q <= IDLE;
                     idx_q   <= '0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end
               default: begin
                  state_q   <= IDLE;
                  pin_sel_q <= '0;
                  busy_q    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign pin_sel       = pin_sel_q;
   assign pin_idx       = idx_q;
   assign sample_strobe = sample_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_analog_pin_scan_ctrl.sv
// Bench for analog_pin_scan_ctrl: a queue-of-cycles reference model compared on every
// cycle, literal scenario tables, async reset, dwell boundary and random traffic.
module tb_analog_pin_scan_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       continuous = 1'b0;
   logic [5:0] pin_mask = '0;
   logic [7:0] dwell = '0;
   logic [5:0] pin_sel;
   logic [2:0] pin_idx;
   logic       sample_strobe;
   logic       busy;
   logic       done;
   logic [1:0] state_dbg;

   int n_checks = 0;
   int n_errors = 0;

   analog_pin_scan_ctrl dut (
      .arduino_clk   (clk),
      .arduino_rst_n (rst_n),
      .start         (start),
      .stop          (stop),
      .continuous    (continuous),
      .pin_mask      (pin_mask),
      .dwell         (dwell),
      .pin_sel       (pin_sel),
      .pin_idx       (pin_idx),
      .sample_strobe (sample_strobe),
      .busy          (busy),
      .done          (done),
      .state_dbg     (state_dbg)
   );

   always #5 clk = ~clk;

   // ---------------- reference model: one queue entry per future output cycle
   typedef struct packed {
      logic [5:0] sel;
      logic [2:0] idx;
      logic       samp;
      logic       busy;
      logic       done;
   } exp_t;

   localparam exp_t IDLE_E = '0;
   localparam exp_t DONE_E = '{sel: 6'd0, idx: 3'd0, samp: 1'b0, busy: 1'b0, done: 1'b1};

   exp_t       exp_q[$];
   exp_t       cur = '0;
   logic [5:0] m_mask = '0;
   logic [7:0] m_dwell = '0;
   logic       m_cont = 1'b0;

   task automatic push_scan();
      for (int p = 0; p < 6; p++) begin
         if (m_mask[p]) begin
            for (int c = 0; c <= int'(m_dwell); c++)
               exp_q.push_back('{sel: 6'(1 << p), idx: 3'(p), samp: (c == int'(m_dwell)),
                                 busy: 1'b1, done: 1'b0});
            exp_q.push_back('{sel: 6'd0, idx: 3'(p), samp: 1'b0, busy: 1'b1, done: 1'b0});
         end
      end
      if (!m_cont) exp_q.push_back(DONE_E);
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         cur = IDLE_E;
      end else if (stop) begin
         exp_q.delete();
         cur = IDLE_E;
      end else if (exp_q.size() != 0) begin
         cur = exp_q.pop_front();
         if (exp_q.size() == 0 && m_cont) push_scan();
      end else if (start) begin
         m_mask  = pin_mask;
         m_dwell = dwell;
         m_cont  = continuous;
         if (m_mask == 6'd0) begin
            cur = DONE_E;
         end else begin
            push_scan();
            cur = exp_q.pop_front();
         end
      end else begin
         cur = IDLE_E;
      end
   end

   // ---------------- per-cycle compare process
   logic [5:0] prev_sel = '0;

   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         n_checks++;
         if ({pin_sel, pin_idx, sample_strobe, busy, done} !== cur) begin
            n_errors++;
            $display("FAIL model t=%0t: got sel=%b idx=%0d smp=%b busy=%b done=%b, expected sel=%b idx=%0d smp=%b busy=%b done=%b",
                     $time, pin_sel, pin_idx, sample_strobe, busy, done,
                     cur.sel, cur.idx, cur.samp, cur.busy, cur.done);
         end
         n_checks++;
         if ($countones(pin_sel) > 1) begin
            n_errors++;
            $display("FAIL onehot t=%0t: got sel=%b, expected at most one bit", $time, pin_sel);
         end
         n_checks++;
         if (prev_sel != 6'd0 && pin_sel != 6'd0 && pin_sel != prev_sel) begin
            n_errors++;
            $display("FAIL gap t=%0t: got sel %b -> %b, expected an all-zero cycle between pins",
                     $time, prev_sel, pin_sel);
         end
         prev_sel = pin_sel;
      end else begin
         prev_sel = '0;
      end
   end

   // ---------------- literal checks and driver helpers
   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s t=%0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   task automatic set_in(input logic s, input logic p, input logic c,
                         input logic [5:0] m, input logic [7:0] d);
      start      = s;
      stop       = p;
      continuous = c;
      pin_mask   = m;
      dwell      = d;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_zero(input string name);
      chk({name, "_sel"}, int'(pin_sel), 0);
      chk({name, "_idx"}, int'(pin_idx), 0);
      chk({name, "_smp"}, int'(sample_strobe), 0);
      chk({name, "_busy"}, int'(busy), 0);
      chk({name, "_done"}, int'(done), 0);
   endtask

   logic [5:0] l_sel[9];
   logic [8:0] l_smp;
   logic [8:0] l_busy;
   logic [8:0] l_done;
   logic [5:0] c_sel[4];
   logic [2:0] c_idx[4];
   int         busy_cnt;
   int         smp_cnt;
   int         sel_cnt;

   task automatic scan1(input string name, input logic latch_test);
      set_in(1'b1, 1'b0, 1'b0, 6'b000101, 8'd2);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (latch_test && k == 2) set_in(1'b1, 1'b0, 1'b1, 6'b111111, 8'd7);
         if (latch_test && k == 3) start = 1'b0;
         chk($sformatf("%s_sel_c%0d", name, k), int'(pin_sel), int'(l_sel[k-1]));
         chk($sformatf("%s_smp_c%0d", name, k), int'(sample_strobe), int'(l_smp[k-1]));
         chk($sformatf("%s_busy_c%0d", name, k), int'(busy), int'(l_busy[k-1]));
         chk($sformatf("%s_done_c%0d", name, k), int'(done), int'(l_done[k-1]));
      end
      set_in(1'b0, 1'b0, 1'b0, 6'd0, 8'd0);
      cyc(2);
   endtask

   initial begin
      l_sel  = '{6'd1, 6'd1, 6'd1, 6'd0, 6'd4, 6'd4, 6'd4, 6'd0, 6'd0};
      l_smp  = 9'b001000100;
      l_busy = 9'b011111111;
      l_done = 9'b100000000;
      c_sel  = '{6'b000010, 6'b000000, 6'b100000, 6'b000000};
      c_idx  = '{3'd1, 3'd1, 3'd5, 3'd5};

      // reset state
      #2;
      chk_zero("reset");
      cyc(2);
      rst_n = 1'b1;
      cyc(1);
      chk_zero("post_reset");

      // single scan with fixed timing table
      scan1("single", 1'b0);

      // mid-scan start with new mask/dwell/mode must be ignored
      scan1("latch", 1'b1);

      // continuous scan, two pins, dwell 0
      set_in(1'b1, 1'b0, 1'b1, 6'b100010, 8'd0);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         chk($sformatf("cont_sel_c%0d", k), int'(pin_sel), int'(c_sel[(k-1)%4]));
         chk($sformatf("cont_idx_c%0d", k), int'(pin_idx), int'(c_idx[(k-1)%4]));
         chk($sformatf("cont_done_c%0d", k), int'(done), 0);
      end
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      chk_zero("cont_stopped");
      cyc(2);

      // zero mask
      set_in(1'b1, 1'b0, 1'b0, 6'd0, 8'd5);
      cyc(1);
      start = 1'b0;
      chk("zmask_done", int'(done), 1);
      chk("zmask_busy", int'(busy), 0);
      chk("zmask_sel", int'(pin_sel), 0);
      cyc(1);
      chk("zmask_done_gone", int'(done), 0);

      // stop in cycle 2 of the single scan
      set_in(1'b1, 1'b0, 1'b0, 6'b000101, 8'd2);
      cyc(1);
      start = 1'b0;
      cyc(1);
      stop = 1'b1;
      cyc(1);
      stop = 1'b0;
      chk("stop_sel", int'(pin_sel), 0);
      chk("stop_busy", int'(busy), 0);
      for (int k = 0; k < 8; k++) begin
         cyc(1);
         chk($sformatf("stop_quiet_%0d", k), int'({pin_sel, busy, done, sample_strobe}), 0);
      end

      // start and stop in the same idle cycle
      set_in(1'b1, 1'b1, 1'b0, 6'b000101, 8'd2);
      cyc(1);
      set_in(1'b0, 1'b0, 1'b0, 6'd0, 8'd0);
      chk("startstop_busy", int'(busy), 0);
      chk("startstop_sel", int'(pin_sel), 0);
      cyc(3);
      chk("startstop_busy_late", int'(busy), 0);

      // asynchronous reset in the middle of a drive
      set_in(1'b1, 1'b0, 1'b0, 6'b010000, 8'd5);
      cyc(1);
      start = 1'b0;
      cyc(1);
      chk("pre_areset_sel", int'(pin_sel), 16);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero("areset");
      @(negedge clk);
      rst_n = 1'b1;
      set_in(1'b1, 1'b0, 1'b0, 6'b000011, 8'd1);
      cyc(1);
      start = 1'b0;
      chk("fresh_sel_c1", int'(pin_sel), 1);
      cyc(2);
      chk("fresh_sel_c3", int'(pin_sel), 0);
      chk("fresh_idx_c3", int'(pin_idx), 0);
      cyc(1);
      chk("fresh_sel_c4", int'(pin_sel), 2);
      cyc(4);

      // maximum dwell: 256 drive cycles plus one gap
      set_in(1'b1, 1'b0, 1'b0, 6'b001000, 8'd255);
      busy_cnt = 0;
      smp_cnt  = 0;
      sel_cnt  = 0;
      for (int k = 0; k < 262; k++) begin
         cyc(1);
         start = 1'b0;
         busy_cnt += int'(busy);
         smp_cnt  += int'(sample_strobe);
         sel_cnt  += int'(pin_sel != 6'd0);
      end
      chk("maxdwell_busy_cycles", busy_cnt, 257);
      chk("maxdwell_sel_cycles", sel_cnt, 256);
      chk("maxdwell_samples", smp_cnt, 1);

      // random traffic against the model
      for (int k = 0; k < 3000; k++) begin
         cyc(1);
         start      = ($urandom_range(0, 3) == 0);
         stop       = ($urandom_range(0, 39) == 0);
         continuous = 1'($urandom_range(0, 1));
         pin_mask   = ($urandom_range(0, 9) == 0) ? 6'd0 : 6'($urandom_range(0, 63));
         dwell      = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 20))
                                                 : 8'($urandom_range(0, 3));
      end
      set_in(1'b0, 1'b1, 1'b0, 6'd0, 8'd0);
      cyc(2);
      stop = 1'b0;
      cyc(2);
      chk_zero("final_idle");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of test, expected completion");
      n_errors++;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

endmodule
